// File: rtl/output_wrapper_pkg.sv
// Shared definitions for the output wrapper: FSM state encoding and the
// 4-phase ready/accepted handshake common to the input and output wrappers.
package output_wrapper_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned N_WORDS_DEF = 4;
  localparam int unsigned STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    S_EMPTY   = 2'd0,
    S_CAPTURE = 2'd1,
    S_PRESENT = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  // Handshake phases as seen on the bus: offer, take, release, idle.
  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_OFFER   = 2'd1,
    HS_TAKEN   = 2'd2,
    HS_RELEASE = 2'd3
  } hs_phase_e;

  function automatic hs_phase_e hs_phase(input logic ready, input logic accepted);
    case ({ready, accepted})
      2'b10:   return HS_OFFER;
      2'b11:   return HS_TAKEN;
      2'b01:   return HS_RELEASE;
      default: return HS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/output_wrapper_if.sv
// Word-streaming handshake bus between the output wrapper and its consumer.
interface output_wrapper_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic [DATA_W-1:0] out_bus;
  logic              out_ready;
  logic              out_accepted;

  modport master (output out_bus, output out_ready, input out_accepted);
  modport slave  (input out_bus, input out_ready, output out_accepted);
endinterface

// File: rtl/output_wrapper_cu.sv
// Control unit of the output wrapper: capture / present / release sequencing.
module output_wrapper_cu
  import output_wrapper_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic done_rise,
  input  logic out_accepted,
  input  logic last,
  output logic ld_buf,
  output logic inz_cnt,
  output logic inc_cnt,
  output logic out_ready,
  output logic empty_buffer,
  output logic set_overrun
);

  state_e state_q, state_d;

  // Status outputs are flops loaded from the next state, so they track state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      out_ready    <= 1'b0;
      empty_buffer <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_ready    <= (state_d == S_PRESENT);
      empty_buffer <= (state_d == S_EMPTY);
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_buf      = 1'b0;
    inz_cnt     = 1'b0;
    inc_cnt     = 1'b0;
    set_overrun = done_rise && (state_q != S_EMPTY);
    case (state_q)
      S_EMPTY: begin
        if (done_rise) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        ld_buf  = 1'b1;
        inz_cnt = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_accepted) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!out_accepted) begin
          if (last) begin
            state_d = S_EMPTY;
          end else begin
            inc_cnt = 1'b1;
            state_d = S_PRESENT;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

endmodule

// File: rtl/output_wrapper.sv
// Output wrapper: captures a finished core result and streams it word by word
// over the ready/accepted handshake, reporting buffer emptiness and overruns.
module output_wrapper
  import output_wrapper_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned N_WORDS = N_WORDS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      core_done,
  input  logic [N_WORDS*DATA_W-1:0] core_result,
  output_wrapper_if.master          ob,
  output logic                      empty_buffer,
  output logic                      overrun
);

  localparam int unsigned CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic              done_q;
  logic              done_rise;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last;
  logic [DATA_W-1:0] buf_q [N_WORDS];
  logic [DATA_W-1:0] out_bus_q;
  logic              ld_buf;
  logic              inz_cnt;
  logic              inc_cnt;
  logic              out_ready;
  logic              set_overrun;

  assign done_rise = core_done & ~done_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last      = (cnt_q == CNT_W'(N_WORDS - 1));

  assign ob.out_bus   = out_bus_q;
  assign ob.out_ready = out_ready;

  output_wrapper_cu u_cu (
    .clk          (clk),
    .rst          (rst),
    .done_rise    (done_rise),
    .out_accepted (ob.out_accepted),
    .last         (last),
    .ld_buf       (ld_buf),
    .inz_cnt      (inz_cnt),
    .inc_cnt      (inc_cnt),
    .out_ready    (out_ready),
    .empty_buffer (empty_buffer),
    .set_overrun  (set_overrun)
  );

  // done_q resets high so an idle core's Done level is not seen as a new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b1;
      overrun   <= 1'b0;
      cnt_q     <= '0;
      out_bus_q <= '0;
      for (int i = 0; i < int'(N_WORDS); i++) buf_q[i] <= '0;
    end else begin
      done_q <= core_done;
      if (set_overrun) overrun <= 1'b1;
      if (ld_buf) begin
        for (int i = 0; i < int'(N_WORDS); i++) buf_q[i] <= core_result[i*DATA_W +: DATA_W];
        out_bus_q <= core_result[DATA_W-1:0];
      end
      if (inz_cnt) begin
        cnt_q <= '0;
      end else if (inc_cnt) begin
        cnt_q     <= cnt_inc;
        out_bus_q <= buf_q[cnt_inc];
      end
    end
  end

endmodule

// File: tb/tb_output_wrapper.sv
// Scoreboard bench for output_wrapper: random results and consumer timing,
// expected words queued at issue time and popped by an independent monitor.
module tb_output_wrapper;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned N_WORDS = 4;
  localparam int unsigned RES_W   = N_WORDS * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             core_done;
  logic [RES_W-1:0] core_result;
  logic             empty_buffer;
  logic             overrun;

  output_wrapper_if #(.DATA_W(DATA_W)) ob ();

  output_wrapper #(.DATA_W(DATA_W), .N_WORDS(N_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_done    (core_done),
    .core_result  (core_result),
    .ob           (ob),
    .empty_buffer (empty_buffer),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_rises = 0;
  logic [DATA_W-1:0] exp_q [$];
  bit exp_overrun = 1'b0;
  int unsigned dly_min = 1, dly_max = 1, hold_min = 1, hold_max = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a result captured into an empty buffer is delivered in word order.
  function automatic void model_capture(input logic [RES_W-1:0] r);
    for (int i = 0; i < int'(N_WORDS); i++) exp_q.push_back(r[i*DATA_W +: DATA_W]);
  endfunction

  function automatic logic [RES_W-1:0] rand_result();
    logic [RES_W-1:0] r;
    for (int i = 0; i < int'(N_WORDS); i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  // Monitor: each new offer of a word is compared with the head of the scoreboard.
  logic prev_rdy = 1'b0;
  logic [DATA_W-1:0] prev_bus = '0;
  always @(negedge clk) begin
    if (ob.out_ready && !prev_rdy) begin
      ready_rises++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", ob.out_bus, $time);
      end else begin
        check("out_bus_word", 64'(ob.out_bus), 64'(exp_q.pop_front()));
      end
    end else if (ob.out_ready && prev_rdy) begin
      check("out_bus_stable", 64'(ob.out_bus), 64'(prev_bus));
    end
    prev_rdy = ob.out_ready;
    prev_bus = ob.out_bus;
  end

  // Consumer: random delay after out_ready, then holds out_accepted for a random time.
  initial begin
    ob.out_accepted = 1'b0;
    forever begin
      @(negedge clk);
      if (ob.out_ready && !rst) begin
        repeat ($urandom_range(dly_max, dly_min)) @(negedge clk);
        if (ob.out_ready) begin
          ob.out_accepted = 1'b1;
          repeat ($urandom_range(hold_max, hold_min)) @(negedge clk);
          ob.out_accepted = 1'b0;
        end
      end
    end
  end

  // Produces one core_done rising edge carrying r, then scrambles core_result.
  task automatic issue(input logic [RES_W-1:0] r, input bit captured);
    @(negedge clk);
    core_done = 1'b0;
    repeat ($urandom_range(3, 1)) @(negedge clk);
    core_result = r;
    core_done   = 1'b1;
    if (captured) model_capture(r);
    else exp_overrun = 1'b1;
    @(negedge clk);
    @(negedge clk);
    core_result = rand_result();
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty_buffer && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!empty_buffer) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got empty_buffer=0 expected 1", name);
    end
  endtask

  task automatic end_of_result(input string name);
    wait_empty(name);
    check({name, "_all_words"}, 64'(exp_q.size()), 64'd0);
    check({name, "_overrun"}, 64'(overrun), 64'(exp_overrun));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int n;
    rst         = 1'b1;
    core_done   = 1'b1;
    core_result = '0;
    repeat (3) @(negedge clk);
    check("rst_out_ready", 64'(ob.out_ready), 64'd0);
    check("rst_empty", 64'(empty_buffer), 64'd1);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_out_bus", 64'(ob.out_bus), 64'd0);

    // Idle Done held through and after reset must not capture.
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("idle_empty", 64'(empty_buffer), 64'd1);
      check("idle_out_ready", 64'(ob.out_ready), 64'd0);
    end

    // Single result with exact latency checks.
    dly_min = 1; dly_max = 1; hold_min = 1; hold_max = 1;
    r0 = ready_rises;
    @(negedge clk); core_done = 1'b0;
    @(negedge clk); @(negedge clk);
    core_result = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    core_done   = 1'b1;
    model_capture(core_result);
    @(negedge clk);
    check("capture_out_ready", 64'(ob.out_ready), 64'd0);
    check("capture_empty", 64'(empty_buffer), 64'd0);
    @(negedge clk);
    check("latency_out_ready", 64'(ob.out_ready), 64'd1);
    core_result = rand_result();
    end_of_result("single");
    check("single_ready_count", 64'(ready_rises - r0), 64'(N_WORDS));

    // Randomized results and consumer timing.
    for (int k = 0; k < 6; k++) begin
      dly_min = 0; dly_max = 5; hold_min = 1; hold_max = 3;
      issue(rand_result(), 1'b1);
      end_of_result("random");
    end

    // Slow consumer.
    dly_min = 5; dly_max = 5; hold_min = 3; hold_max = 3;
    issue(rand_result(), 1'b1);
    end_of_result("slow");

    // Overrun: second result arrives while the second word is pending.
    dly_min = 3; dly_max = 3; hold_min = 1; hold_max = 1;
    issue({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1);
    n = 0;
    while (exp_q.size() > N_WORDS - 2 && n < 500) begin @(negedge clk); n++; end
    check("overrun_word2_seen", 64'(exp_q.size()), 64'(N_WORDS - 2));
    issue({RES_W{1'b1}}, 1'b0);
    end_of_result("overrun");
    repeat (4) @(negedge clk);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Asynchronous reset after the first word is accepted.
    dly_min = 1; dly_max = 1; hold_min = 1; hold_max = 1;
    issue(rand_result(), 1'b1);
    n = 0;
    while (!ob.out_accepted && n < 500) begin @(negedge clk); n++; end
    while (ob.out_accepted && n < 500) begin @(negedge clk); n++; end
    check("midrst_pending", 64'(exp_q.size()), 64'(N_WORDS - 1));
    #2 rst = 1'b1;
    #1;
    check("midrst_out_ready", 64'(ob.out_ready), 64'd0);
    check("midrst_empty", 64'(empty_buffer), 64'd1);
    check("midrst_overrun", 64'(overrun), 64'd0);
    exp_q.delete();
    exp_overrun = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_bus", 64'(ob.out_bus), 64'd0);
    issue(rand_result(), 1'b1);
    end_of_result("after_rst");

    // Back-to-back: next rising edge one cycle after empty_buffer rises.
    dly_min = 0; dly_max = 2; hold_min = 1; hold_max = 2;
    issue(rand_result(), 1'b1);
    core_done = 1'b0;
    wait_empty("b2b_first");
    core_result = rand_result();
    core_done   = 1'b1;
    model_capture(core_result);
    @(negedge clk);
    check("b2b_capture_empty", 64'(empty_buffer), 64'd0);
    @(negedge clk);
    core_result = rand_result();
    end_of_result("b2b_second");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_wrapper.md
Name: output_wrapper

Overview:
- Downstream stage of the input wrapper and compute core.
- On completion of a calculation (rising edge of core_done), captures the core's N_WORDS-wide result vector into a local buffer.
- Streams the buffer one word at a time on out_bus, using the same 4-phase ready/accepted handshake as the input side.
- Drives empty_buffer back to the input wrapper's control unit, which gates the start of the next calculation.

Parameters:
- DATA_W, 16, width of one output word.
- N_WORDS, 4, words per result; must be ≥2. Counter width is clog2(N_WORDS).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- core_done  input  1  compute core Done level: high when idle or finished, low while calculating.
- core_result  input  N_WORDS*DATA_W  result vector; word i = bits [i*DATA_W +: DATA_W]. Valid when core_done is high.
- out_bus  output  DATA_W  current output word.
- out_ready  output  1  out_bus holds a valid word.
- out_accepted  input  1  consumer has taken the word.
- empty_buffer  output  1  buffer holds no undelivered words.
- overrun  output  1  sticky: a result arrived while the buffer was not empty.

Behaviour:
- Reset values: out_bus=0, out_ready=0, empty_buffer=1, overrun=0, word counter=0, state=S_EMPTY, done_q=1.
  - done_q resets to 1 so that the core's idle Done=1 does not cause a spurious capture.
- Edge detection: done_q<=core_done every cycle. done_rise = core_done & ~done_q.
- FSM states:
  - S_EMPTY: empty_buffer=1. On done_rise → S_CAPTURE.
  - S_CAPTURE (1 cycle):
    - buffer<=core_result; cnt<=0; out_bus<=word0.
    - empty_buffer=0 from this state on.
    - → S_PRESENT.
  - S_PRESENT: out_ready=1 while out_bus is held stable. If out_accepted=1 → S_RELEASE, else stay.
  - S_RELEASE: out_ready=0. Stay while out_accepted=1. When out_accepted=0:
    - if cnt==N_WORDS-1 → S_EMPTY;
    - else cnt<=cnt+1, out_bus<=buffer[cnt+1], → S_PRESENT.
- Latency:
  - done_rise sampled at edge t; S_CAPTURE during cycle t+1; out_ready=1 in cycle t+2.
  - Minimum per-word period is 2 cycles, achieved when out_accepted is high for exactly one cycle.
  - empty_buffer rises in the cycle after the final out_accepted deassertion is sampled.
- Outputs decode from state (Moore) and do not depend combinationally on out_accepted. out_bus is a register.
- out_accepted already high on entry to S_PRESENT: counts as acceptance; → S_RELEASE next edge.
- done_rise in any state other than S_EMPTY:
  - result is dropped and the buffer is unchanged;
  - overrun<=1 and stays 1 until rst.
  - The same-cycle case of S_RELEASE → S_EMPTY also counts as not-empty and sets overrun.
- out_bus retains the last delivered word in S_EMPTY.
- Reset mid-transfer: immediate return to reset values; the remaining words are discarded. The consumer must tolerate out_ready dropping.
- core_result is sampled only in S_CAPTURE; changes at other times have no effect.

Decomposition:
- Shared package: state encoding localparams (S_EMPTY, S_CAPTURE, S_PRESENT, S_RELEASE, 2-bit) and the handshake phase description common to the input and output wrappers.
- One sub-module: output_wrapper_cu (FSM only).
  - Inputs: done_rise, out_accepted, last (cnt==N_WORDS-1).
  - Outputs: ld_buf, inz_cnt, inc_cnt, out_ready, empty_buffer, set_overrun.
- The top level holds the datapath: buffer registers, counter, out_bus register, done_q and overrun flop.

Test Plan (DATA_W=16, N_WORDS=4):
- Single result:
  - Stimulus: core_done 1→0→1 with core_result={16'h4444,16'h3333,16'h2222,16'h1111}; consumer acks each word for 1 cycle, 1 cycle after out_ready.
  - Required response: out_bus sequence 1111, 2222, 3333, 4444; out_ready high exactly 4 times; empty_buffer 1→0→1; overrun=0.
- Reset behaviour:
  - Stimulus: hold core_done=1 through and after reset.
  - Required response: no capture; empty_buffer stays 1; out_ready stays 0.
- Slow consumer:
  - Stimulus: out_accepted asserted 5 cycles after out_ready, held high 3 cycles.
  - Required response: out_ready stays high until accepted; no word skipped or repeated; cnt advances only after out_accepted=0.
- Overrun:
  - Stimulus: second core_done rising edge while word 2 is pending, new result all 16'hFFFF.
  - Required response: remaining words still 3333 and 4444; overrun=1 and stays high after empty_buffer returns to 1.
- Reset mid-transfer:
  - Stimulus: rst pulse after word 1 is accepted.
  - Required response: out_ready=0 and empty_buffer=1 immediately (asynchronous); the next result is delivered starting from word 0.
- Back-to-back results:
  - Stimulus: second core_done rising edge 1 cycle after empty_buffer rises.
  - Required response: captured normally; overrun stays 0; second sequence delivered in order.
